// File: rtl/morse_decoder_pkg.sv
// rtl/morse_decoder_pkg.sv - Morse letter codes, symbol tables and decoder state encoding
package morse_decoder_pkg;

    localparam int PAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MARK   = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESYNC = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        LTR_S = 3'd0,
        LTR_T = 3'd1,
        LTR_U = 3'd2,
        LTR_V = 3'd3,
        LTR_W = 3'd4,
        LTR_X = 3'd5,
        LTR_Y = 3'd6,
        LTR_Z = 3'd7
    } letter_t;

    typedef struct packed {
        logic    hit;
        letter_t code;
    } decode_t;

    // Number of dots/dashes making up each letter
    function automatic int sym_count(input logic [2:0] code);
        int n;
        case (code)
            LTR_T:               n = 1;
            LTR_S, LTR_U, LTR_W: n = 3;
            default:             n = 4;
        endcase
        return n;
    endfunction

    // Symbol pattern, first symbol in bit 0, dash = 1, unused upper bits 0
    function automatic logic [PAT_W-1:0] sym_pattern(input logic [2:0] code);
        logic [PAT_W-1:0] p;
        case (code)
            LTR_S:   p = 4'b0000;
            LTR_T:   p = 4'b0001;
            LTR_U:   p = 4'b0100;
            LTR_V:   p = 4'b1000;
            LTR_W:   p = 4'b0110;
            LTR_X:   p = 4'b1001;
            LTR_Y:   p = 4'b1101;
            default: p = 4'b0011;
        endcase
        return p;
    endfunction

    // Search the table for a collected symbol buffer
    function automatic decode_t decode_letter(input int cnt, input logic [PAT_W-1:0] pat);
        decode_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (sym_count(3'(i)) == cnt && sym_pattern(3'(i)) == pat) begin
                r.hit  = 1'b1;
                r.code = letter_t'(3'(i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - run-length timer in Morse units with edge restart and saturation
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    output logic [2:0] units
);
    localparam int               CYC_W    = $clog2(UNIT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(UNIT_CYCLES / 2);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_nxt;

    // Phase within the current unit; wrapping makes the half-unit boundary recur every UNIT_CYCLES
    always_comb begin
        cyc_nxt = (cyc == CYC_LAST) ? '0 : cyc + CYC_ONE;
    end

    // The restart cycle is the run's cycle 0, so the phase resumes at 1; units saturate at 7
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc   <= '0;
            units <= 3'd0;
        end else if (restart) begin
            cyc   <= CYC_ONE;
            units <= 3'd0;
        end else begin
            cyc <= cyc_nxt;
            if (cyc_nxt == CYC_HALF && units != 3'd7) begin
                units <= units + 3'd1;
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse receiver decoding S..Z from mark/space run lengths (option: MORSE_DEC_SYNC_EN)
module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000,
    parameter int MAX_SYMS    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       morse_in,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);
    localparam int CNT_W = $clog2(MAX_SYMS + 1);

    logic             in_src;
    logic             in_q;
    logic             in_d;
    logic             rise;
    logic             fall;
    logic             run_edge;
    logic [2:0]       units;
    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] sym_buf;
    logic [PAT_W-1:0] buf_nxt;
    logic [CNT_W-1:0] sym_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       letter_nxt;
    logic             valid_nxt;
    logic             error_nxt;
    logic             sym_ok;
    logic             sym_dash;
    decode_t          dec;

`ifdef MORSE_DEC_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for a source outside the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], morse_in};
        end
    end

    assign in_src = sync_q[1];
`else
    assign in_src = morse_in;
`endif

    // Input register and its one-cycle-old copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
            in_d <= 1'b0;
        end else begin
            in_q <= in_src;
            in_d <= in_q;
        end
    end

    assign rise     = in_q & ~in_d;
    assign fall     = ~in_q & in_d;
    assign run_edge = rise | fall;
    assign sym_ok   = (units == 3'd1) || (units == 3'd3);
    assign sym_dash = (units == 3'd3);
    assign busy     = (state == ST_MARK) || (state == ST_GAP);

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (run_edge),
        .units   (units)
    );

    // Next state, symbol collection and decode; units still hold the finishing run on an edge cycle
    always_comb begin
        state_nxt  = state;
        buf_nxt    = sym_buf;
        cnt_nxt    = sym_cnt;
        letter_nxt = letter;
        valid_nxt  = 1'b0;
        error_nxt  = 1'b0;
        dec        = decode_letter(int'(sym_cnt), sym_buf);
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_MARK;
                    buf_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_MARK: begin
                if (fall) begin
                    if (!sym_ok || int'(sym_cnt) >= MAX_SYMS) begin
                        error_nxt = 1'b1;
                        state_nxt = ST_RESYNC;
                    end else begin
                        buf_nxt   = sym_buf | ({{(PAT_W-1){1'b0}}, sym_dash} << sym_cnt);
                        cnt_nxt   = sym_cnt + CNT_W'(1);
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (rise) begin
                    if (units == 3'd1) begin
                        state_nxt = ST_MARK;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = ST_RESYNC;
                    end
                end else if (!in_q && !run_edge && units >= 3'd3) begin
                    if (dec.hit) begin
                        letter_nxt = dec.code;
                        valid_nxt  = 1'b1;
                    end else begin
                        error_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (!in_q && !run_edge && units >= 3'd3) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // State, symbol buffer and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sym_buf <= '0;
            sym_cnt <= '0;
            letter  <= 3'd0;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            sym_buf <= buf_nxt;
            sym_cnt <= cnt_nxt;
            letter  <= letter_nxt;
            valid   <= valid_nxt;
            error   <= error_nxt;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - randomized scoreboard bench for morse_decoder against a run-level Morse model
module tb_morse_decoder;
    localparam int U    = 4;
    localparam int MAXS = 4;
`ifdef MORSE_DEC_SYNC_EN
    localparam int SA = 2;
`else
    localparam int SA = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic       morse_in;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    morse_decoder #(
        .UNIT_CYCLES(U),
        .MAX_SYMS   (MAXS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .morse_in (morse_in),
        .letter   (letter),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    typedef struct {
        bit is_err;
        int letter;
        int cyc;
    } exp_t;

    typedef enum {M_IDLE, M_COLLECT, M_RESYNC} mstate_e;

    exp_t    sbq[$];
    int      mq[$];
    int      gq[$];
    int      checks     = 0;
    int      errors     = 0;
    int      cyc_cnt    = 0;
    int      exp_letter = 0;
    string   pats[8];
    string   sym        = "";
    mstate_e ms         = M_IDLE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc_cnt);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic int lookup(input string s);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) begin
            if (pats[i] == s) r = i;
        end
        return r;
    endfunction

    task automatic push_exp(input bit is_err, input int code, input int at);
        exp_t e;
        if (!is_err) exp_letter = code;
        e.is_err = is_err;
        e.letter = exp_letter;
        e.cyc    = at;
        sbq.push_back(e);
    endtask

    task automatic hold(input int u);
        repeat (u * U) @(posedge clk);
        #1;
    endtask

    task automatic add(input int m, input int g);
        mq.push_back(m);
        gq.push_back(g);
    endtask

    // Drive queued (mark, gap) runs and predict decoder events from the Morse rules
    task automatic play();
        int m;
        int g;
        int c;
        int code;
        while (mq.size() > 0) begin
            m = mq.pop_front();
            g = gq.pop_front();
            morse_in = 1'b1;
            if (ms == M_IDLE) begin
                ms  = M_COLLECT;
                sym = "";
            end
            hold(m);
            c = cyc_cnt;
            morse_in = 1'b0;
            if (ms == M_COLLECT) begin
                if ((m != 1 && m != 3) || sym.len() == MAXS) begin
                    push_exp(1'b1, 0, c + 2 + SA);
                    ms = M_RESYNC;
                end else if (m == 1) begin
                    sym = {sym, "."};
                end else begin
                    sym = {sym, "-"};
                end
            end
            if (ms == M_COLLECT) begin
                if (g >= 3) begin
                    code = lookup(sym);
                    push_exp(code < 0, code, c + U / 2 + 2 * U + 2 + SA);
                    ms = M_IDLE;
                end else if (g == 2) begin
                    push_exp(1'b1, 0, c + g * U + 2 + SA);
                    ms = M_RESYNC;
                end
            end else if (ms == M_RESYNC && g >= 3) begin
                ms = M_IDLE;
            end
            hold(g);
        end
    endtask

    task automatic rand_word();
        int n;
        int r;
        int m;
        int k;
        if ($urandom_range(0, 1) == 0) begin
            k = $urandom_range(0, 7);
            for (int i = 0; i < pats[k].len(); i++) begin
                add((pats[k][i] == ".") ? 1 : 3, 1);
            end
        end else begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 19);
                m = (r < 9) ? 1 : (r < 18) ? 3 : (r == 18) ? 2 : 4;
                r = $urandom_range(0, 19);
                add(m, (r == 0) ? 2 : 1);
            end
        end
        gq[gq.size() - 1] = $urandom_range(3, 7);
    endtask

    // Scoreboard monitor: every valid/error pulse must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && (valid || error)) begin
            chk("valid_error_exclusive", int'(valid && error), 0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: valid=%0b error=%0b letter=%0d at cycle %0d, nothing expected",
                         valid, error, letter, cyc_cnt);
            end else begin
                e = sbq.pop_front();
                chk("event_kind(1=error)", int'(error), int'(e.is_err));
                chk("letter", int'(letter), e.letter);
                chk("event_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    initial begin
        pats[0] = "...";
        pats[1] = "-";
        pats[2] = "..-";
        pats[3] = "...-";
        pats[4] = ".--";
        pats[5] = "-..-";
        pats[6] = "-.--";
        pats[7] = "--..";

        reset_n  = 1'b0;
        morse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_letter", int'(letter), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_error", int'(error), 0);
        chk("reset_busy", int'(busy), 0);
        reset_n = 1'b1;
        hold(2);

        // S with a 4-unit trailing space
        add(1, 1); add(1, 1); add(1, 4);
        play();
        chk("busy_idle_after_S", int'(busy), 0);

        // 2-unit mark, then T
        add(2, 3);
        add(3, 4);
        play();

        // five dots overflow, then W
        for (int i = 0; i < 4; i++) add(1, 1);
        add(1, 3);
        play();
        add(1, 1); add(3, 1); add(3, 4);
        play();

        // -.. is not in the table
        add(3, 1); add(1, 1); add(1, 3);
        play();

        // reset during the second mark of U
        add(1, 1);
        play();
        morse_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_letter", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_letter", int'(letter), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_error", int'(error), 0);
        chk("abort_busy", int'(busy), 0);
        ms         = M_IDLE;
        exp_letter = 0;
        morse_in   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold(2);

        // V after the abort
        add(1, 1); add(1, 1); add(1, 1); add(3, 4);
        play();

        for (int w = 0; w < 60; w++) begin
            rand_word();
            play();
        end

        hold(10);
        chk("pending_expected_events", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
